// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_responder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   localparam int   WSTRB_W    = 4;
   localparam int   WORD_BYTES = 4;
   localparam logic RSP_ERR    = 1'b1;
   localparam logic RSP_OK     = 1'b0;

   // Misaligned or beyond the array; upper address bits are compared, never dropped.
   function automatic logic addr_err(input logic [31:0] addr, input logic [31:0] depth_words);
      logic misaligned_s;
      logic out_of_range_s;
      misaligned_s   = (addr[1:0] != 2'b00);
      out_of_range_s = ({2'b00, addr[31:2]} >= depth_words);
      return (misaligned_s || out_of_range_s) ? RSP_ERR : RSP_OK;
   endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response channel between the CPU load/store unit and the data-memory responder.
interface dmem_responder_if;
   import dmem_responder_pkg::*;

   logic               req_valid;
   logic               req_ready;
   logic               req_we;
   logic [31:0]        req_addr;
   logic [31:0]        req_wdata;
   logic [WSTRB_W-1:0] req_wstrb;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [31:0]        rsp_rdata;
   logic               rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_array.sv
// Byte-enabled synchronous word RAM with a registered read port; contents are never reset.
module dmem_array
   import dmem_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int IDX_W       = 10
) (
   input  logic               clk,
   input  logic               we,
   input  logic [WSTRB_W-1:0] wstrb,
   input  logic [IDX_W-1:0]   widx,
   input  logic [31:0]        wdata,
   input  logic [IDX_W-1:0]   ridx,
   output logic [31:0]        rdata
);
   logic [31:0] mem_r [DEPTH_WORDS];

   // Byte-masked write and registered read on the same edge.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < WORD_BYTES; b++) begin
            if (wstrb[b]) begin
               mem_r[widx][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
      end
      rdata <= mem_r[ridx];
   end
endmodule

// File: rtl/dmem_responder.sv
// Handshaked data-memory responder: accepts one load/store at a time, inserts
// WAIT_STATES wait cycles, then returns read data and error status.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_STATES = 2
) (
   input logic             clk,
   input logic             reset,
   dmem_responder_if.slave bus
);
   localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_STATES - 1);
   localparam logic [31:0] DEPTH_W32 = 32'(DEPTH_WORDS);
   localparam logic        NO_WAIT   = (WAIT_STATES == 32'sd0);

   state_e             state_r;
   logic [3:0]         cnt_r;
   logic               we_r;
   logic [31:0]        addr_r;
   logic [31:0]        wdata_r;
   logic [WSTRB_W-1:0] wstrb_r;
   logic               req_ready_r;
   logic               rsp_valid_r;
   logic               rsp_err_r;
   logic               rd_ok_r;

   logic               accept_s;
   logic               enter_resp_s;
   logic               cur_we_s;
   logic               cur_err_s;
   logic               ram_we_s;
   logic [31:0]        cur_addr_s;
   logic [31:0]        cur_wdata_s;
   logic [WSTRB_W-1:0] cur_wstrb_s;
   logic [IDX_W-1:0]   cur_idx_s;
   logic [31:0]        ram_rdata_s;

   // In IDLE the live request drives the array so a zero-wait access completes on its accept edge.
   always_comb begin
      accept_s = bus.req_valid && req_ready_r;
      if (state_r == ST_IDLE) begin
         cur_we_s    = bus.req_we;
         cur_addr_s  = bus.req_addr;
         cur_wdata_s = bus.req_wdata;
         cur_wstrb_s = bus.req_wstrb;
      end else begin
         cur_we_s    = we_r;
         cur_addr_s  = addr_r;
         cur_wdata_s = wdata_r;
         cur_wstrb_s = wstrb_r;
      end
      cur_idx_s = cur_addr_s[IDX_W+1:2];
      cur_err_s = addr_err(cur_addr_s, DEPTH_W32);
      if (state_r == ST_IDLE) begin
         enter_resp_s = accept_s && NO_WAIT;
      end else if (state_r == ST_WAIT) begin
         enter_resp_s = (cnt_r == 4'd0);
      end else begin
         enter_resp_s = 1'b0;
      end
      ram_we_s = enter_resp_s && cur_we_s && !cur_err_s;
   end

   // Control FSM with registered handshake and response outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         cnt_r       <= 4'd0;
         we_r        <= 1'b0;
         addr_r      <= 32'd0;
         wdata_r     <= 32'd0;
         wstrb_r     <= {WSTRB_W{1'b0}};
         req_ready_r <= 1'b0;
         rsp_valid_r <= 1'b0;
         rsp_err_r   <= 1'b0;
         rd_ok_r     <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  we_r        <= bus.req_we;
                  addr_r      <= bus.req_addr;
                  wdata_r     <= bus.req_wdata;
                  wstrb_r     <= bus.req_wstrb;
                  req_ready_r <= 1'b0;
                  if (enter_resp_s) begin
                     state_r     <= ST_RESP;
                     rsp_valid_r <= 1'b1;
                     rsp_err_r   <= cur_err_s;
                     rd_ok_r     <= !cur_we_s && !cur_err_s;
                  end else begin
                     state_r <= ST_WAIT;
                     cnt_r   <= WAIT_LOAD;
                  end
               end else begin
                  req_ready_r <= 1'b1;
               end
            end
            ST_WAIT: begin
               if (enter_resp_s) begin
                  state_r     <= ST_RESP;
                  rsp_valid_r <= 1'b1;
                  rsp_err_r   <= cur_err_s;
                  rd_ok_r     <= !cur_we_s && !cur_err_s;
               end else begin
                  cnt_r <= cnt_r - 4'd1;
               end
            end
            ST_RESP: begin
               // Ready is raised only after the handshake edge, so no same-cycle accept.
               if (bus.rsp_ready) begin
                  state_r     <= ST_IDLE;
                  rsp_valid_r <= 1'b0;
                  rsp_err_r   <= 1'b0;
                  rd_ok_r     <= 1'b0;
                  req_ready_r <= 1'b1;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               rsp_valid_r <= 1'b0;
               rsp_err_r   <= 1'b0;
               rd_ok_r     <= 1'b0;
               req_ready_r <= 1'b0;
            end
         endcase
      end
   end

   dmem_array #(
      .DEPTH_WORDS(DEPTH_WORDS),
      .IDX_W      (IDX_W)
   ) u_array (
      .clk  (clk),
      .we   (ram_we_s),
      .wstrb(cur_wstrb_s),
      .widx (cur_idx_s),
      .wdata(cur_wdata_s),
      .ridx (cur_idx_s),
      .rdata(ram_rdata_s)
   );

   // Array output is held by the unchanged read index while in RESP.
   assign bus.req_ready = req_ready_r;
   assign bus.rsp_valid = rsp_valid_r;
   assign bus.rsp_err   = rsp_err_r;
   assign bus.rsp_rdata = rd_ok_r ? ram_rdata_s : 32'd0;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, backpressure and reset sequences,
// randomized traffic against a word-level model, and zero-wait throughput.
module tb_dmem_responder;
   localparam int DEPTH = 1024;
   localparam int WS    = 2;
   localparam int NV    = 22;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   vec_t        tbl [NV];
   logic [31:0] mdl [int];
   int          pool [8] = '{0, 1, 2, 3, 509, 1021, 1022, 1023};
   logic [31:0] w1 [4];

   dmem_responder_if b0();
   dmem_responder_if b1();

   dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut0 (.clk(clk), .reset(reset), .bus(b0));
   dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0))  dut1 (.clk(clk), .reset(reset), .bus(b1));

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic timed_out(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: timed out waiting for DUT", name);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb);
      int n;
      n = 0;
      b0.req_valid = 1'b1;
      b0.req_we    = we;
      b0.req_addr  = addr;
      b0.req_wdata = wdata;
      b0.req_wstrb = wstrb;
      while (b0.req_ready !== 1'b1 && n < 50) begin
         step();
         n++;
      end
      if (n >= 50) timed_out("req_ready");
      step();
      // Request fields are don't-care once accepted.
      b0.req_valid = 1'b0;
      b0.req_we    = 1'($urandom_range(0, 1));
      b0.req_addr  = $urandom();
      b0.req_wdata = $urandom();
      b0.req_wstrb = 4'($urandom());
   endtask

   task automatic wait_rsp(output int lat);
      lat = 1;
      while (b0.rsp_valid !== 1'b1 && lat < 50) begin
         step();
         lat++;
      end
      if (b0.rsp_valid !== 1'b1) timed_out("rsp_valid");
   endtask

   task automatic txn(input string name, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] wstrb, input int bp,
                      output logic [31:0] rd, output logic err);
      int lat;
      b0.rsp_ready = (bp == 0);
      send_req(we, addr, wdata, wstrb);
      wait_rsp(lat);
      check({name, "_lat"}, 32'(lat), 32'(WS + 1));
      for (int i = 0; i < bp; i++) step();
      rd  = b0.rsp_rdata;
      err = b0.rsp_err;
      b0.rsp_ready = 1'b1;
      step();
      check({name, "_drop"}, 32'(b0.rsp_valid), 32'd0);
   endtask

   initial begin
      int          lat;
      int          k;
      int          cyc;
      int          n;
      int          sel;
      int          bp;
      logic        acc;
      logic [31:0] rd;
      logic        err;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] exp_rd;
      logic        exp_err;
      logic [31:0] tmp;
      int unsigned widx;

      tbl[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 1'b0};
      tbl[1]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'hF, 32'hDEAD_BEEF, 1'b0};
      tbl[2]  = '{1'b1, 32'h0000_0010, 32'h0000_00AA, 4'h1, 32'h0000_0000, 1'b0};
      tbl[3]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'h0, 32'hDEAD_BEAA, 1'b0};
      tbl[4]  = '{1'b1, 32'h0000_0010, 32'h1234_5678, 4'h0, 32'h0000_0000, 1'b0};
      tbl[5]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'hF, 32'hDEAD_BEAA, 1'b0};
      tbl[6]  = '{1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'hF, 32'h0000_0000, 1'b0};
      tbl[7]  = '{1'b0, 32'h0000_0013, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b1};
      tbl[8]  = '{1'b0, 32'h0000_1000, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b1};
      tbl[9]  = '{1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000, 1'b1};
      tbl[10] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'hF, 32'hCAFE_F00D, 1'b0};
      tbl[11] = '{1'b1, 32'h0000_0FFC, 32'h0102_0304, 4'hF, 32'h0000_0000, 1'b0};
      tbl[12] = '{1'b0, 32'h0000_0FFC, 32'h0000_0000, 4'hF, 32'h0102_0304, 1'b0};
      tbl[13] = '{1'b0, 32'h8000_0000, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b1};
      tbl[14] = '{1'b1, 32'h0000_0002, 32'h5555_5555, 4'hF, 32'h0000_0000, 1'b1};
      tbl[15] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'hF, 32'hCAFE_F00D, 1'b0};
      tbl[16] = '{1'b1, 32'h0000_0024, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000, 1'b0};
      tbl[17] = '{1'b1, 32'h0000_0024, 32'h0000_AB00, 4'h2, 32'h0000_0000, 1'b0};
      tbl[18] = '{1'b1, 32'h0000_0024, 32'h7700_0000, 4'h8, 32'h0000_0000, 1'b0};
      tbl[19] = '{1'b0, 32'h0000_0024, 32'h0000_0000, 4'hF, 32'h77FF_ABFF, 1'b0};
      tbl[20] = '{1'b1, 32'h0000_0020, 32'h1111_1111, 4'hF, 32'h0000_0000, 1'b0};
      tbl[21] = '{1'b0, 32'h0000_0020, 32'h0000_0000, 4'hF, 32'h1111_1111, 1'b0};

      b0.req_valid = 1'b0; b0.req_we = 1'b0; b0.req_addr = 32'd0;
      b0.req_wdata = 32'd0; b0.req_wstrb = 4'h0; b0.rsp_ready = 1'b0;
      b1.req_valid = 1'b0; b1.req_we = 1'b0; b1.req_addr = 32'd0;
      b1.req_wdata = 32'd0; b1.req_wstrb = 4'h0; b1.rsp_ready = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_req_ready", 32'(b0.req_ready), 32'd0);
      check("rst_rsp_valid", 32'(b0.rsp_valid), 32'd0);
      check("rst_rsp_rdata", b0.rsp_rdata, 32'd0);
      check("rst_rsp_err",   32'(b0.rsp_err), 32'd0);
      check("rst_req_ready_z", 32'(b1.req_ready), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      step();
      step();
      check("idle_req_ready", 32'(b0.req_ready), 32'd1);

      // Directed vector table
      for (int i = 0; i < NV; i++) begin
         txn("vec", tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].wstrb, 0, rd, err);
         check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rdata);
         check($sformatf("vec%0d_err", i), 32'(err), 32'(tbl[i].exp_err));
      end

      // Backpressure: response frozen, a pending request is never taken meanwhile
      b0.rsp_ready = 1'b0;
      send_req(1'b0, 32'h0000_0FFC, 32'h0, 4'h0);
      wait_rsp(lat);
      check("bp_lat", 32'(lat), 32'(WS + 1));
      b0.req_valid = 1'b1;
      b0.req_we    = 1'b1;
      b0.req_addr  = 32'h0000_0000;
      b0.req_wdata = 32'hBADB_AD00;
      b0.req_wstrb = 4'hF;
      for (int i = 0; i < 10; i++) begin
         step();
         check("bp_flags", {29'd0, b0.rsp_valid, b0.req_ready, b0.rsp_err}, 32'd4);
         check("bp_rdata", b0.rsp_rdata, 32'h0102_0304);
      end
      b0.rsp_ready = 1'b1;
      step();
      b0.req_valid = 1'b0;
      check("bp_after_valid", 32'(b0.rsp_valid), 32'd0);
      check("bp_after_ready", 32'(b0.req_ready), 32'd1);
      txn("bp_noaccept", 1'b0, 32'h0000_0000, 32'h0, 4'h0, 0, rd, err);
      check("bp_noaccept_rdata", rd, 32'hCAFE_F00D);

      // Reset one cycle after accepting a store: store must be dropped
      b0.rsp_ready = 1'b1;
      send_req(1'b1, 32'h0000_0020, 32'h2222_2222, 4'hF);
      step();
      reset = 1'b1;
      #1;
      check("midrst_rsp_valid", 32'(b0.rsp_valid), 32'd0);
      check("midrst_req_ready", 32'(b0.req_ready), 32'd0);
      step();
      step();
      @(negedge clk);
      reset = 1'b0;
      step();
      step();
      txn("midrst_load", 1'b0, 32'h0000_0020, 32'h0, 4'h0, 0, rd, err);
      check("midrst_rdata", rd, 32'h1111_1111);
      check("midrst_err", 32'(err), 32'd0);

      // Randomized traffic against a word-level model
      for (int i = 0; i < 8; i++) begin
         wdata = $urandom();
         txn("seed", 1'b1, 32'(pool[i]) * 32'd4, wdata, 4'hF, 0, rd, err);
         check("seed_err", 32'(err), 32'd0);
         mdl[pool[i]] = wdata;
      end
      for (int t = 0; t < 150; t++) begin
         we    = 1'($urandom_range(0, 1));
         sel   = int'($urandom_range(0, 9));
         wdata = $urandom();
         wstrb = 4'($urandom());
         bp    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
         if (sel < 7)       addr = 32'(pool[$urandom_range(0, 7)]) * 32'd4;
         else if (sel == 7) addr = 32'(pool[$urandom_range(0, 7)]) * 32'd4 + 32'($urandom_range(1, 3));
         else if (sel == 8) addr = 32'(DEPTH) * 32'd4 + 32'($urandom_range(0, 1000)) * 32'd4;
         else               addr = 32'h8000_0000 + 32'(pool[$urandom_range(0, 7)]) * 32'd4;
         exp_err = (addr % 32'd4 != 32'd0) || (addr / 32'd4 >= 32'(DEPTH));
         exp_rd  = 32'd0;
         if (!exp_err) begin
            widx = addr / 32'd4;
            if (we) begin
               tmp = mdl[int'(widx)];
               for (int b = 0; b < 4; b++) begin
                  if (wstrb[b]) tmp[8*b +: 8] = wdata[8*b +: 8];
               end
               mdl[int'(widx)] = tmp;
            end else begin
               exp_rd = mdl[int'(widx)];
            end
         end
         txn("rand", we, addr, wdata, wstrb, bp, rd, err);
         check("rand_rdata", rd, exp_rd);
         check("rand_err", 32'(err), 32'(exp_err));
      end

      // Zero wait states: back-to-back with req_valid and rsp_ready held high
      b1.rsp_ready = 1'b1;
      n = 0;
      while (b1.req_ready !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      if (n >= 20) timed_out("z_req_ready");
      b1.req_valid = 1'b1;
      k   = 0;
      cyc = 0;
      while (k < 8 && cyc < 40) begin
         acc = (b1.req_ready === 1'b1);
         if (acc) begin
            if (k < 4) begin
               w1[k]        = $urandom();
               b1.req_we    = 1'b1;
               b1.req_addr  = 32'((k + 8) * 4);
               b1.req_wdata = w1[k];
               b1.req_wstrb = 4'hF;
            end else begin
               b1.req_we    = 1'b0;
               b1.req_addr  = 32'((k - 4 + 8) * 4);
               b1.req_wdata = $urandom();
            end
         end
         step();
         cyc++;
         if (acc) begin
            check("z_acc_flags", {30'd0, b1.rsp_valid, b1.req_ready}, 32'd2);
            check("z_err", 32'(b1.rsp_err), 32'd0);
            if (k >= 4) check("z_rdata", b1.rsp_rdata, w1[k-4]);
            k++;
         end else begin
            check("z_idle_flags", {30'd0, b1.rsp_valid, b1.req_ready}, 32'd1);
         end
      end
      if (k < 8) timed_out("z_throughput");
      b1.req_valid = 1'b0;
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Handshaked data-memory responder: the target end of the CPU load/store port.
- Accepts one word-addressed read or write request at a time over a valid/ready request channel.
- Inserts a configurable number of wait states.
- Returns data plus error status over a valid/ready response channel.
- Replaces the combinational data memory once the core moves to a stallable memory interface; sits between the CPU LSU and on-chip RAM.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array (power of two not required)
WAIT_STATES, 2, extra cycles between request acceptance and response (0..15)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_we  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_wdata  input  32  store data
req_wstrb  input  4  byte enables for store (bit i -> wdata[8i+7:8i])
rsp_valid  output  1  response present
rsp_ready  input  1  requester accepts response
rsp_rdata  output  32  load data (0 for stores and errors)
rsp_err  output  1  1 = misaligned or out-of-range access

Behaviour:
- Reset (async assert, sync release): state=IDLE, wait counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0 while reset high.
- Memory array is not reset. Contents persist across reset; power-up contents are undefined.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1, rsp_valid=0.
  - On req_valid&&req_ready, capture addr/we/wdata/wstrb.
  - Go to WAIT if WAIT_STATES>0 (counter loaded with WAIT_STATES-1), else RESP.
- WAIT:
  - req_ready=0; counter decrements each cycle.
  - At counter==0, go to RESP.
- Transition into RESP (single edge):
  - Error check: err = (addr[1:0]!=0) || (addr[31:2] >= DEPTH_WORDS).
  - Store, no error: bytes with wstrb=1 written; other bytes unchanged. wstrb=0000 is a legal no-op.
  - Load, no error: rsp_rdata <= mem[addr[31:2]].
  - Store or error: rsp_rdata <= 0. On error, no array write occurs.
- RESP:
  - rsp_valid=1, req_ready=0.
  - rsp_rdata/rsp_err held stable until rsp_ready.
  - On rsp_valid&&rsp_ready, go to IDLE; rsp_valid drops next cycle.
  - No request is accepted in the same cycle as the response handshake.
- Latency: acceptance edge to rsp_valid high = WAIT_STATES+1 cycles.
- Peak throughput: one transaction per WAIT_STATES+2 cycles, with rsp_ready held high.
- req_* may change freely while req_ready=0; they are sampled only on the accept edge.
- Backpressure: rsp_ready low indefinitely keeps the FSM in RESP with outputs frozen.
- Reset mid-transaction: transaction discarded. If reset arrives before the RESP-entry edge, no array write occurs. A write already performed is kept.
- Load-after-store to the same address returns the stored data. The array is written before the next acceptance, so no hazard exists.
- Address boundaries:
  - Highest legal word = DEPTH_WORDS-1.
  - addr = 4*DEPTH_WORDS sets the error.
  - Address bits above the index are checked, never aliased.

Decomposition:
- Shared package: FSM state encoding (IDLE/WAIT/RESP), WSTRB_W=4, WORD_BYTES=4, response error constant, a function returning the err condition.
- One natural sub-module: dmem_array. A byte-enabled synchronous RAM with ports clk, we, wstrb, widx, wdata, ridx, rdata; registered read; no reset.
- FSM, counter and error check stay in dmem_responder.

Test Plan:
- WAIT_STATES=2. Store 0xDEADBEEF to 0x10 with wstrb=1111, then load 0x10.
  - Store response rsp_err=0, rdata=0, rsp_valid 3 cycles after acceptance.
  - Load returns 0xDEADBEEF.
- Store 0x000000AA to 0x10 with wstrb=0001 after the first test → load 0x10 returns 0xDEADBEAA. wstrb=0000 store → value unchanged.
- Load from 0x13 (misaligned), then from 4*DEPTH_WORDS.
  - Both give rsp_err=1, rdata=0.
  - Store to 4*DEPTH_WORDS leaves word 0 unchanged (no aliasing).
- Hold rsp_ready=0 for 10 cycles in RESP.
  - rsp_valid, rdata and err stay stable; req_ready=0 throughout.
  - Raise rsp_ready: one-cycle handshake, then req_ready=1 the following cycle.
- Assert reset one cycle after a store to 0x20 is accepted, with prior content 0x11111111 and WAIT_STATES=2.
  - Immediately rsp_valid=0 and req_ready=0.
  - After release, load 0x20 returns 0x11111111.
- WAIT_STATES=0 back-to-back loads with req_valid and rsp_ready held high → accepts every 2 cycles, rsp_valid one cycle after each acceptance.
